write_arbiter: RTL and testbench
================================

Name: write_arbiter

Overview:
- Write-side counterpart of the interconnect's read arbiter; sits between M AXI masters and S slaves.
- Arbitrates the write-address (AW) channel round-robin across masters.
- Steers write data (W) strictly in AW-acceptance order.
- Arbitrates write responses (B) round-robin across slaves, routing each back to the master encoded in its ID.

Parameters:
- M, 2, number of masters (>=2)
- S, 2, number of slaves (>=2)
- NUM_OUTSTANDING_TRANS, 2, max outstanding writes per master (>=2)
- ADDR_WIDTH, 32, address width
- SLICE_SIZE, 32'h00010000, address span per slave; power of two

Ports:
- clk  in  1  clock
- clr  in  1  asynchronous active-low reset
- AW_request_f  in  M  per-master AW request
- AW_addr_f  in  M*ADDR_WIDTH  per-master address, master i at [(i+1)*ADDR_WIDTH-1 : i*ADDR_WIDTH]
- AW_id_f  in  M*IW  per-master transaction id, IW=$clog2(NUM_OUTSTANDING_TRANS)
- AW_grant_f  out  M  AW grant
- AW_sel_f  out  M*SW  decoded slave per master, SW=$clog2(S)
- W_request_f  in  M  per-master W beat valid
- W_last_f  in  M  per-master last beat
- W_grant_f  out  M  W grant
- W_sel_f  out  M*SW  slave targeted by master's W data
- B_request_f  in  S  per-slave B response valid
- B_id_f  in  S*(MW+IW)  response id {master_id[MW], trans_id[IW]}, MW=$clog2(M)
- B_grant_f  out  S  B grant
- B_sel_f  out  S*MW  destination master per slave

Behaviour:
- Reset (clr low, async): all grants 0; W_sel_f and B_sel_f 0; all FSMs IDLE; all pointers 0; order FIFO empty; outstanding counters 0. Reset mid-burst drops grants immediately.
- Decode (combinational, always driven):
  - AW_sel[i] = (AW_addr[i] / SLICE_SIZE) truncated to SW bits.
  - Example: 0x0001_0004 -> 1.
- AW FSM, states AW_IDLE / AW_ALLOW:
  - Pointer aw_ptr.
  - Accept condition in AW_IDLE: AW_request[aw_ptr] && out_cnt[aw_ptr] < NUM_OUTSTANDING_TRANS && !fifo_full.
  - On accept: push {aw_ptr, AW_sel[aw_ptr]} into the order FIFO in that same edge; go to AW_ALLOW.
  - Otherwise: aw_ptr <= (aw_ptr+1)%M.
  - AW_ALLOW: AW_grant[aw_ptr]=1, all other AW grants 0.
  - Leave AW_ALLOW when AW_request[aw_ptr]=0: go to AW_IDLE, aw_ptr advances.
  - Latency: request sampled at edge n gives grant in cycle n+1.
- Outstanding counters:
  - out_cnt[m] increments on each AW accept for m and decrements on each B completion for m.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - Counters never exceed NUM_OUTSTANDING_TRANS and never underflow; a B completion with a zero counter is ignored.
- W FSM, states W_IDLE / W_ALLOW:
  - W_IDLE: if FIFO not empty, go to W_ALLOW. FIFO contents are registered, so an entry pushed at edge n is eligible at edge n+1.
  - W_ALLOW with head {hm, hs}: W_grant[hm]=1 and W_sel[hm]=hs; all other W grants and sels 0.
  - Exit W_ALLOW when W_request[hm] && W_last[hm]: pop the FIFO and return to W_IDLE.
  - Beats without last stay in W_ALLOW.
- B FSM, states B_IDLE / B_ALLOW:
  - Pointer b_ptr.
  - B_IDLE: if B_request[b_ptr], go to B_ALLOW; otherwise b_ptr <= (b_ptr+1)%S.
  - B_ALLOW: B_grant[b_ptr]=1 and B_sel[b_ptr] = master_id field of B_id[b_ptr].
  - B_sel of every non-granted slave also shows its own decoded master_id.
  - Exit B_ALLOW when B_request[b_ptr]=0: B completion for that master, b_ptr advances, return to B_IDLE.
- Order FIFO:
  - Depth M*NUM_OUTSTANDING_TRANS; full is unreachable under the counters but is still checked.
  - Simultaneous push and pop is legal when non-empty; pointers wrap modulo depth.
- The three FSMs are independent. AW, W and B may each hold a grant in the same cycle.

Decomposition:
- Shared package (axi_ic_pkg):
  - state encodings: AW_IDLE=0, AW_ALLOW=1, W_IDLE=0, W_ALLOW=1, B_IDLE=0, B_ALLOW=1
  - width helpers IW, MW, SW
  - default SLICE_SIZE
- One sub-module: write_order_fifo.
  - Synchronous, async active-low clr.
  - Parameters DATA_WIDTH=MW+SW and DEPTH.
  - Ports push, pop, data_in, head, empty, full.

Test Plan:
- Single write: master0 AW addr 0x0001_0000 -> AW_grant_f=01 the cycle after request, AW_sel_f[0]=1. Then W beats, last on beat 4 -> W_grant_f[0]=1 and W_sel_f[0]=1 for 4 cycles, then 0. Slave1 B_id={0,0} -> B_grant_f=10, B_sel_f[1]=0.
- Ordering: master1 AW to slave0 accepted before master0 AW to slave1 -> master1 W granted first with W_sel=0. Master0 W grant follows only after master1's W_last.
- Outstanding limit: master0 issues 3 AWs with NUM_OUTSTANDING_TRANS=2 and no B returned -> third AW_grant withheld. After one B for master0 completes -> third AW granted.
- Round-robin: both masters request continuously -> AW grants alternate 01,10,01; both slaves hold B_request -> B grants alternate 01,10.
- Simultaneous events: AW accept and B completion for master0 in the same cycle -> out_cnt[0] unchanged. FIFO push and pop in the same cycle -> occupancy unchanged, head advances.
- Reset mid-burst: clr low during W_ALLOW -> all grants 0 asynchronously. After release, FIFO is empty and no W grant appears until a new AW is accepted.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared state encodings and width helpers for the interconnect arbiters
package axi_ic_pkg;

  typedef enum logic {AW_IDLE = 1'b0, AW_ALLOW = 1'b1} aw_state_t;
  typedef enum logic {W_IDLE  = 1'b0, W_ALLOW  = 1'b1} w_state_t;
  typedef enum logic {B_IDLE  = 1'b0, B_ALLOW  = 1'b1} b_state_t;

  localparam logic [31:0] DEFAULT_SLICE_SIZE = 32'h0001_0000;

  // Index fields never collapse to zero bits, so a count of two still gets one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int iw_of(input int num_outstanding);
    return idx_width(num_outstanding);
  endfunction

  function automatic int mw_of(input int num_masters);
    return idx_width(num_masters);
  endfunction

  function automatic int sw_of(input int num_slaves);
    return idx_width(num_slaves);
  endfunction

endpackage

// File: rtl/write_order_fifo.sv
// rtl/write_order_fifo.sv - order FIFO recording {master, slave} of accepted write addresses
module write_order_fifo
  import axi_ic_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic                  full
);

  localparam int              PW         = idx_width(DEPTH);
  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]   PTR_LAST   = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_arbiter.sv
// rtl/write_arbiter.sv - AW/W/B write-channel arbiter between M masters and S slaves
module write_arbiter
  import axi_ic_pkg::*;
#(
  parameter int          M                     = 2,
  parameter int          S                     = 2,
  parameter int          NUM_OUTSTANDING_TRANS = 2,
  parameter int          ADDR_WIDTH            = 32,
  parameter logic [31:0] SLICE_SIZE            = DEFAULT_SLICE_SIZE,
  localparam int         IW                    = iw_of(NUM_OUTSTANDING_TRANS),
  localparam int         MW                    = mw_of(M),
  localparam int         SW                    = sw_of(S)
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [M-1:0]            AW_request_f,
  input  logic [M*ADDR_WIDTH-1:0] AW_addr_f,
  input  logic [M*IW-1:0]         AW_id_f,
  output logic [M-1:0]            AW_grant_f,
  output logic [M*SW-1:0]         AW_sel_f,
  input  logic [M-1:0]            W_request_f,
  input  logic [M-1:0]            W_last_f,
  output logic [M-1:0]            W_grant_f,
  output logic [M*SW-1:0]         W_sel_f,
  input  logic [S-1:0]            B_request_f,
  input  logic [S*(MW+IW)-1:0]    B_id_f,
  output logic [S-1:0]            B_grant_f,
  output logic [S*MW-1:0]         B_sel_f
);

  localparam int            BW          = MW + IW;
  localparam int            CW          = $clog2(NUM_OUTSTANDING_TRANS + 1);
  localparam int            SLICE_SHIFT = $clog2(SLICE_SIZE);
  localparam int            FIFO_DEPTH  = M * NUM_OUTSTANDING_TRANS;
  localparam logic [CW-1:0] MAX_CNT     = CW'(NUM_OUTSTANDING_TRANS);
  localparam logic [MW-1:0] M_LAST      = MW'(M - 1);
  localparam logic [SW-1:0] S_LAST      = SW'(S - 1);

  logic [SW-1:0] aw_sel      [M];
  logic [MW-1:0] b_master_id [S];
  logic [CW-1:0] out_cnt     [M];
  logic          unused_ids;

  aw_state_t     aw_state;
  logic [MW-1:0] aw_ptr;
  logic [MW-1:0] aw_ptr_next;
  logic          aw_accept;
  logic [M-1:0]  aw_grant_next;

  w_state_t      w_state;
  logic [M-1:0]  w_grant_next;
  logic [M*SW-1:0] w_sel_next;

  b_state_t      b_state;
  logic [SW-1:0] b_ptr;
  logic [SW-1:0] b_ptr_next;
  logic [MW-1:0] b_master_q;
  logic          b_done;
  logic [S-1:0]  b_grant_next;

  logic [M-1:0]  cnt_inc;
  logic [M-1:0]  cnt_dec;

  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [MW+SW-1:0]  fifo_head;
  logic [MW-1:0]     head_master;
  logic [SW-1:0]     head_slave;

  // Transaction ids only travel with the data; routing needs just the master field.
  assign unused_ids = ^{AW_id_f, B_id_f};

  always_comb begin
    AW_sel_f = '0;
    aw_sel   = '{default: '0};
    for (int i = 0; i < M; i++) begin
      aw_sel[i] = SW'(AW_addr_f[i*ADDR_WIDTH +: ADDR_WIDTH] >> SLICE_SHIFT);
      AW_sel_f[i*SW +: SW] = aw_sel[i];
    end
  end

  always_comb begin
    b_master_id = '{default: '0};
    for (int s = 0; s < S; s++) begin
      b_master_id[s] = B_id_f[s*BW + IW +: MW];
    end
  end

  assign aw_ptr_next = (aw_ptr == M_LAST) ? '0 : aw_ptr + MW'(1);
  assign b_ptr_next  = (b_ptr == S_LAST) ? '0 : b_ptr + SW'(1);
  assign aw_accept   = (aw_state == AW_IDLE) && AW_request_f[aw_ptr]
                       && (out_cnt[aw_ptr] < MAX_CNT) && !fifo_full;
  assign b_done      = (b_state == B_ALLOW) && !B_request_f[b_ptr];

  assign head_master = fifo_head[SW +: MW];
  assign head_slave  = fifo_head[SW-1:0];
  assign fifo_pop    = (w_state == W_ALLOW) && W_request_f[head_master]
                       && W_last_f[head_master];

  always_comb begin
    aw_grant_next = '0;
    w_grant_next  = '0;
    w_sel_next    = '0;
    for (int m = 0; m < M; m++) begin
      if (aw_ptr == MW'(m)) begin
        aw_grant_next[m] = 1'b1;
      end
      if (head_master == MW'(m)) begin
        w_grant_next[m]          = 1'b1;
        w_sel_next[m*SW +: SW]   = head_slave;
      end
    end
  end

  always_comb begin
    b_grant_next = '0;
    for (int s = 0; s < S; s++) begin
      if (b_ptr == SW'(s)) begin
        b_grant_next[s] = 1'b1;
      end
    end
  end

  write_order_fifo #(
    .DATA_WIDTH (MW + SW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push    (aw_accept),
    .pop     (fifo_pop),
    .data_in ({aw_ptr, aw_sel[aw_ptr]}),
    .head    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      aw_state   <= AW_IDLE;
      aw_ptr     <= '0;
      AW_grant_f <= '0;
    end else begin
      case (aw_state)
        AW_IDLE: begin
          if (aw_accept) begin
            aw_state   <= AW_ALLOW;
            AW_grant_f <= aw_grant_next;
          end else begin
            aw_ptr <= aw_ptr_next;
          end
        end
        AW_ALLOW: begin
          if (!AW_request_f[aw_ptr]) begin
            aw_state   <= AW_IDLE;
            AW_grant_f <= '0;
            aw_ptr     <= aw_ptr_next;
          end
        end
        default: aw_state <= AW_IDLE;
      endcase
    end
  end

  // A completion arriving for an idle master is dropped rather than wrapping the counter.
  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int m = 0; m < M; m++) begin
      cnt_inc[m] = aw_accept && (aw_ptr == MW'(m));
      cnt_dec[m] = b_done && (b_master_q == MW'(m)) && (out_cnt[m] != '0);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      out_cnt <= '{default: '0};
    end else begin
      for (int m = 0; m < M; m++) begin
        if (cnt_inc[m] && !cnt_dec[m]) begin
          out_cnt[m] <= out_cnt[m] + CW'(1);
        end else if (cnt_dec[m] && !cnt_inc[m]) begin
          out_cnt[m] <= out_cnt[m] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      w_state   <= W_IDLE;
      W_grant_f <= '0;
      W_sel_f   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (!fifo_empty) begin
            w_state   <= W_ALLOW;
            W_grant_f <= w_grant_next;
            W_sel_f   <= w_sel_next;
          end
        end
        W_ALLOW: begin
          if (fifo_pop) begin
            w_state   <= W_IDLE;
            W_grant_f <= '0;
            W_sel_f   <= '0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      b_state    <= B_IDLE;
      b_ptr      <= '0;
      b_master_q <= '0;
      B_grant_f  <= '0;
      B_sel_f    <= '0;
    end else begin
      // The granted slave keeps the destination captured at grant time.
      for (int s = 0; s < S; s++) begin
        if (!((b_state == B_ALLOW) && (b_ptr == SW'(s)))) begin
          B_sel_f[s*MW +: MW] <= b_master_id[s];
        end
      end
      case (b_state)
        B_IDLE: begin
          if (B_request_f[b_ptr]) begin
            b_state    <= B_ALLOW;
            B_grant_f  <= b_grant_next;
            b_master_q <= b_master_id[b_ptr];
          end else begin
            b_ptr <= b_ptr_next;
          end
        end
        B_ALLOW: begin
          if (b_done) begin
            b_state   <= B_IDLE;
            B_grant_f <= '0;
            b_ptr     <= b_ptr_next;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_arbiter.sv
// tb/tb_write_arbiter.sv - directed self-checking bench for write_arbiter
module tb_write_arbiter;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  AW_request_f;
  logic [63:0] AW_addr_f;
  logic [1:0]  AW_id_f;
  logic [1:0]  AW_grant_f;
  logic [1:0]  AW_sel_f;
  logic [1:0]  W_request_f;
  logic [1:0]  W_last_f;
  logic [1:0]  W_grant_f;
  logic [1:0]  W_sel_f;
  logic [1:0]  B_request_f;
  logic [3:0]  B_id_f;
  logic [1:0]  B_grant_f;
  logic [1:0]  B_sel_f;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [1:0]  sel;
    string       name;
  } dec_vec_t;

  dec_vec_t    dv [6];
  logic [1:0]  rr_exp [3];

  write_arbiter dut (
    .clk          (clk),
    .clr          (clr),
    .AW_request_f (AW_request_f),
    .AW_addr_f    (AW_addr_f),
    .AW_id_f      (AW_id_f),
    .AW_grant_f   (AW_grant_f),
    .AW_sel_f     (AW_sel_f),
    .W_request_f  (W_request_f),
    .W_last_f     (W_last_f),
    .W_grant_f    (W_grant_f),
    .W_sel_f      (W_sel_f),
    .B_request_f  (B_request_f),
    .B_id_f       (B_id_f),
    .B_grant_f    (B_grant_f),
    .B_sel_f      (B_sel_f)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  function automatic logic [1:0] grant_of(input int ch);
    case (ch)
      0:       return AW_grant_f;
      1:       return W_grant_f;
      default: return B_grant_f;
    endcase
  endfunction

  task automatic wait_grant(input int ch, input logic [1:0] mask, input int budget);
    for (int k = 0; k < budget; k++) begin
      if ((grant_of(ch) & mask) != 2'b00) break;
      tick();
    end
  endtask

  task automatic clear_inputs();
    AW_request_f = '0;
    AW_addr_f    = '0;
    AW_id_f      = '0;
    W_request_f  = '0;
    W_last_f     = '0;
    B_request_f  = '0;
    B_id_f       = '0;
  endtask

  initial begin
    clr = 1'b0;
    clear_inputs();

    dv[0] = '{32'h0001_0004, 32'h0000_0000, 2'b01, "dec_basic"};
    dv[1] = '{32'h0000_FFFF, 32'h0001_0000, 2'b10, "dec_slice_edge"};
    dv[2] = '{32'h0002_0000, 32'h0003_FFFF, 2'b10, "dec_truncate"};
    dv[3] = '{32'hFFFF_FFFF, 32'h0004_0000, 2'b01, "dec_top_addr"};
    dv[4] = '{32'h0001_FFFF, 32'h0005_0000, 2'b11, "dec_both_one"};
    dv[5] = '{32'h0000_0000, 32'h0000_0000, 2'b00, "dec_zero"};
    rr_exp[0] = 2'b01;
    rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01;

    // Reset state and combinational decode while held in reset
    tick();
    check("rst_aw_grant", AW_grant_f, 2'b00);
    check("rst_w_grant", W_grant_f, 2'b00);
    check("rst_b_grant", B_grant_f, 2'b00);
    check("rst_w_sel", W_sel_f, 2'b00);
    check("rst_b_sel", B_sel_f, 2'b00);
    check("rst_fifo_empty", dut.u_fifo.empty, 1'b1);
    for (int i = 0; i < 6; i++) begin
      AW_addr_f = {dv[i].addr1, dv[i].addr0};
      #1;
      check(dv[i].name, AW_sel_f, dv[i].sel);
    end
    AW_addr_f = '0;

    // Single write: master0 -> slave1, four W beats, B from slave1
    do_reset();
    AW_addr_f    = {32'h0, 32'h0001_0000};
    AW_request_f = 2'b01;
    #1;
    check("t1_aw_sel", AW_sel_f, 2'b01);
    tick();
    check("t1_aw_grant", AW_grant_f, 2'b01);
    check("t1_w_not_yet", W_grant_f, 2'b00);
    AW_request_f = 2'b00;
    tick();
    check("t1_aw_released", AW_grant_f, 2'b00);
    W_request_f = 2'b01;
    for (int beat = 1; beat <= 4; beat++) begin
      check($sformatf("t1_w_grant_beat%0d", beat), W_grant_f, 2'b01);
      check($sformatf("t1_w_sel_beat%0d", beat), W_sel_f, 2'b01);
      W_last_f = (beat == 4) ? 2'b01 : 2'b00;
      tick();
    end
    W_request_f = 2'b00;
    W_last_f    = 2'b00;
    check("t1_w_grant_done", W_grant_f, 2'b00);
    check("t1_w_sel_done", W_sel_f, 2'b00);
    B_id_f      = 4'b0000;
    B_request_f = 2'b10;
    wait_grant(2, 2'b10, 6);
    check("t1_b_grant", B_grant_f, 2'b10);
    check("t1_b_sel", B_sel_f[1], 1'b0);
    B_request_f = 2'b00;
    tick();
    check("t1_b_released", B_grant_f, 2'b00);
    check("t1_cnt0_after_b", dut.out_cnt[0], 0);

    // Ordering: master1 (slave0) accepted before master0 (slave1)
    clear_inputs();
    do_reset();
    AW_addr_f    = {32'h0000_0000, 32'h0001_0000};
    AW_request_f = 2'b10;
    wait_grant(0, 2'b10, 4);
    check("t2_aw_m1", AW_grant_f, 2'b10);
    AW_request_f = 2'b01;
    tick();
    check("t2_w_m1_first", W_grant_f, 2'b10);
    check("t2_w_sel_m1", W_sel_f, 2'b00);
    W_request_f = 2'b10;
    tick();
    check("t2_aw_m0", AW_grant_f, 2'b01);
    check("t2_w_m1_hold", W_grant_f, 2'b10);
    AW_request_f = 2'b00;
    W_last_f     = 2'b10;
    tick();
    check("t2_w_m1_done", W_grant_f, 2'b00);
    W_request_f = 2'b00;
    W_last_f    = 2'b00;
    tick();
    check("t2_w_m0_second", W_grant_f, 2'b01);
    check("t2_w_sel_m0", W_sel_f, 2'b01);
    W_request_f = 2'b01;
    W_last_f    = 2'b01;
    tick();
    W_request_f = 2'b00;
    W_last_f    = 2'b00;
    tick();
    check("t2_w_idle", W_grant_f, 2'b00);
    check("t2_fifo_empty", dut.u_fifo.empty, 1'b1);

    // Outstanding limit: third AW from master0 waits for a B completion
    clear_inputs();
    do_reset();
    for (int t = 0; t < 2; t++) begin
      AW_request_f = 2'b01;
      wait_grant(0, 2'b01, 6);
      check($sformatf("t3_aw_%0d", t), AW_grant_f, 2'b01);
      AW_request_f = 2'b00;
      tick();
    end
    AW_request_f = 2'b01;
    repeat (6) tick();
    check("t3_third_withheld", AW_grant_f, 2'b00);
    check("t3_cnt0_full", dut.out_cnt[0], 2);
    B_id_f      = 4'b0000;
    B_request_f = 2'b01;
    wait_grant(2, 2'b01, 6);
    check("t3_b_grant", B_grant_f, 2'b01);
    B_request_f = 2'b00;
    wait_grant(0, 2'b01, 8);
    check("t3_third_granted", AW_grant_f, 2'b01);
    AW_request_f = 2'b00;

    // Round-robin on AW and B with both requesters always active
    clear_inputs();
    AW_request_f = 2'b11;
    B_request_f  = 2'b11;
    B_id_f       = 4'b0110;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      wait_grant(0, 2'b11, 4);
      check($sformatf("t4_aw_rr%0d", k), AW_grant_f, rr_exp[k]);
      check($sformatf("t4_b_rr%0d", k), B_grant_f, rr_exp[k]);
      check($sformatf("t4_b_sel%0d", k), B_sel_f, 2'b01);
      AW_request_f = AW_request_f & ~AW_grant_f;
      B_request_f  = B_request_f & ~B_grant_f;
      tick();
      AW_request_f = 2'b11;
      B_request_f  = 2'b11;
    end
    AW_request_f = 2'b00;
    B_request_f  = 2'b00;
    tick();
    check("t4_cnt0", dut.out_cnt[0], 1);
    check("t4_cnt1_no_underflow", dut.out_cnt[1], 0);

    // Same-edge AW accept with B completion, and FIFO push with pop
    clear_inputs();
    AW_request_f = 2'b01;
    B_request_f  = 2'b01;
    do_reset();
    tick();
    check("t5_aw_first", AW_grant_f, 2'b01);
    check("t5_b_grant", B_grant_f, 2'b01);
    AW_request_f = 2'b00;
    tick();
    check("t5_w_head0", W_grant_f, 2'b01);
    check("t5_w_sel_head0", W_sel_f, 2'b00);
    AW_addr_f    = {32'h0, 32'h0001_0000};
    AW_request_f = 2'b01;
    tick();
    B_request_f = 2'b00;
    W_request_f = 2'b01;
    W_last_f    = 2'b01;
    tick();
    check("t5_aw_second", AW_grant_f, 2'b01);
    check("t5_b_done", B_grant_f, 2'b00);
    check("t5_cnt0_unchanged", dut.out_cnt[0], 1);
    check("t5_fifo_count", dut.u_fifo.count, 1);
    check("t5_w_popped", W_grant_f, 2'b00);
    AW_request_f = 2'b00;
    W_request_f  = 2'b00;
    W_last_f     = 2'b00;
    tick();
    check("t5_w_head1", W_grant_f, 2'b01);
    check("t5_w_sel_head1", W_sel_f, 2'b01);

    // Reset in the middle of a W burst
    clear_inputs();
    AW_request_f = 2'b01;
    AW_addr_f    = {32'h0, 32'h0001_0000};
    do_reset();
    tick();
    W_request_f = 2'b01;
    B_request_f = 2'b01;
    tick();
    tick();
    check("t6_pre_aw", AW_grant_f, 2'b01);
    check("t6_pre_w", W_grant_f, 2'b01);
    check("t6_pre_b", B_grant_f, 2'b01);
    #2;
    clr = 1'b0;
    #1;
    check("t6_async_aw", AW_grant_f, 2'b00);
    check("t6_async_w", W_grant_f, 2'b00);
    check("t6_async_b", B_grant_f, 2'b00);
    check("t6_async_w_sel", W_sel_f, 2'b00);
    tick();
    clear_inputs();
    clr = 1'b1;
    repeat (4) tick();
    check("t6_no_w_after", W_grant_f, 2'b00);
    check("t6_fifo_empty", dut.u_fifo.empty, 1'b1);
    AW_request_f = 2'b01;
    wait_grant(1, 2'b01, 8);
    check("t6_w_new", W_grant_f, 2'b01);
    AW_request_f = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
